// File: rtl/clock_pkg.sv
// Shared constants for the BCD time-of-day counter: FSM encodings, digit
// field offsets within the packed HH:MM:SS word, and per-digit limits.
package clock_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CHK  = 2'd2;

    // Bit offsets of each digit in {h_t,h_u,m_t,m_u,s_t,s_u}
    localparam int unsigned OFS_S_U = 0;
    localparam int unsigned OFS_S_T = 4;
    localparam int unsigned OFS_M_U = 8;
    localparam int unsigned OFS_M_T = 12;
    localparam int unsigned OFS_H_U = 16;
    localparam int unsigned OFS_H_T = 20;

    // Digit limits
    localparam logic [3:0] DIGIT_MAX     = 4'd9;
    localparam logic [3:0] SEC_T_MAX     = 4'd5;
    localparam logic [3:0] MIN_T_MAX     = 4'd5;
    localparam logic [3:0] HR_T_MAX      = 4'd2;
    localparam logic [3:0] HR_U_MAX_AT_2 = 4'd3;

    // True when a packed time is a legal 24-hour BCD time
    function automatic logic time_valid(input logic [23:0] t);
        logic [3:0] s_u, s_t, m_u, m_t, h_u, h_t;
        s_u = t[OFS_S_U +: 4];
        s_t = t[OFS_S_T +: 4];
        m_u = t[OFS_M_U +: 4];
        m_t = t[OFS_M_T +: 4];
        h_u = t[OFS_H_U +: 4];
        h_t = t[OFS_H_T +: 4];
        return (s_u <= DIGIT_MAX) && (s_t <= SEC_T_MAX) &&
               (m_u <= DIGIT_MAX) && (m_t <= MIN_T_MAX) &&
               (h_u <= DIGIT_MAX) && (h_t <= HR_T_MAX) &&
               ((h_t != HR_T_MAX) || (h_u <= HR_U_MAX_AT_2));
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: increments on inc_i, wraps to 0 past max_i with a carry,
// or takes load_val_i when load_i is set (load wins).
module bcd_digit_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic [3:0] max_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] value_o,
    output logic [3:0] next_o,
    output logic       carry_o
);

    logic [3:0] value_q, value_d;

    // Next value: load, wrap past limit, or increment
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = (value_q >= max_i) ? 4'd0 : value_q + 4'd1;
        end
    end

    // Digit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign carry_o = inc_i && !load_i && (value_q >= max_i);
    assign value_o = value_q;
    // Post-update value, used for the alarm compare ahead of the register
    assign next_o  = value_d;

endmodule

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter with one-second prescaler, validated
// load over valid/ready, and alarm match on the seconds tick.
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic        load_valid,
    input  logic [23:0] load_time,
    output logic        load_ready,
    output logic        load_ok,
    output logic        load_err,
    input  logic [23:0] alarm_time,
    input  logic        alarm_en,
    output logic        alarm_hit,
    output logic [23:0] digits,
    output logic        sec_tick,
    output logic        day_wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   stage_q, stage_d;
    logic          sec_tick_q, day_wrap_q, alarm_hit_q, load_ok_q, load_err_q;

    logic          in_run, in_chk, accept, tick, stage_ok, load_apply;
    logic [5:0]    inc, carry;
    logic [23:0]   cur, nxt;
    logic [3:0]    dig_max [6];

    assign in_run     = (state_q == ST_RUN);
    assign in_chk     = (state_q == ST_CHK);
    assign load_ready = !in_chk;
    assign accept     = load_valid && load_ready;
    assign tick       = in_run && (presc_q == PRESC_MAX);
    assign stage_ok   = time_valid(stage_q);
    assign load_apply = in_chk && stage_ok;

    // Next state: accepted load always goes to CHK, otherwise follow run_en
    always_comb begin
        state_d = run_en ? ST_RUN : ST_STOP;
        if (accept) begin
            state_d = ST_CHK;
        end
    end

    // Prescaler advances only in RUN; a valid load restarts the second
    always_comb begin
        presc_d = presc_q;
        if (load_apply) begin
            presc_d = '0;
        end else if (in_run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Staging register captures the load word on handshake
    always_comb begin
        stage_d = stage_q;
        if (accept) begin
            stage_d = load_time;
        end
    end

    // Per-digit wrap limits; hour units stop at 3 once the tens reach 2
    always_comb begin
        dig_max[0] = DIGIT_MAX;
        dig_max[1] = SEC_T_MAX;
        dig_max[2] = DIGIT_MAX;
        dig_max[3] = MIN_T_MAX;
        dig_max[4] = (cur[OFS_H_T +: 4] == HR_T_MAX) ? HR_U_MAX_AT_2 : DIGIT_MAX;
        dig_max[5] = HR_T_MAX;
    end

    assign inc = {carry[4:0], tick};

    for (genvar g = 0; g < 6; g++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .inc_i      (inc[g]),
            .max_i      (dig_max[g]),
            .load_i     (load_apply),
            .load_val_i (stage_q[4*g +: 4]),
            .value_o    (cur[4*g +: 4]),
            .next_o     (nxt[4*g +: 4]),
            .carry_o    (carry[g])
        );
    end

    // FSM, prescaler, staging and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOP;
            presc_q     <= '0;
            stage_q     <= '0;
            sec_tick_q  <= 1'b0;
            day_wrap_q  <= 1'b0;
            alarm_hit_q <= 1'b0;
            load_ok_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            stage_q     <= stage_d;
            sec_tick_q  <= tick;
            day_wrap_q  <= carry[5];
            // Ticks never coincide with a load, so nxt is the incremented time
            alarm_hit_q <= tick && alarm_en && (nxt == alarm_time);
            load_ok_q   <= load_apply;
            load_err_q  <= in_chk && !stage_ok;
        end
    end

    assign digits    = cur;
    assign sec_tick  = sec_tick_q;
    assign day_wrap  = day_wrap_q;
    assign alarm_hit = alarm_hit_q;
    assign load_ok   = load_ok_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter with a 4-cycle second.
module tb_bcd_time_counter;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst_n, run_en, load_valid, alarm_en;
    logic [23:0] load_time, alarm_time, digits;
    logic        load_ready, load_ok, load_err, alarm_hit, sec_tick, day_wrap;

    bcd_time_counter #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_en     (run_en),
        .load_valid (load_valid),
        .load_time  (load_time),
        .load_ready (load_ready),
        .load_ok    (load_ok),
        .load_err   (load_err),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .alarm_hit  (alarm_hit),
        .digits     (digits),
        .sec_tick   (sec_tick),
        .day_wrap   (day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic        wrap;
        logic        alarm;
    } exp_t;

    exp_t sbq[$];
    int   vec_cnt = 0;
    int   miscmp  = 0;
    int   tick_cnt = 0, alarm_cnt = 0, wrap_cnt = 0, ldp_cnt = 0;
    int   now_s = 0;

    function automatic logic [23:0] to_bcd(input int s);
        int t, h, m, sc;
        t  = s % 86400;
        h  = t / 3600;
        m  = (t / 60) % 60;
        sc = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic void push_sec(input int s, input logic alarm);
        exp_t e;
        e.d     = to_bcd(s);
        e.wrap  = ((s % 86400) == 0);
        e.alarm = alarm;
        sbq.push_back(e);
    endfunction

    task automatic pop_exp(output exp_t e, output bit have);
        have = (sbq.size() > 0);
        e.d = 24'hxxxxxx; e.wrap = 1'bx; e.alarm = 1'bx;
        if (have) e = sbq.pop_front();
    endtask

    // Advance to next negedge and tally output pulses
    task automatic step();
        @(negedge clk);
        if (sec_tick)  tick_cnt++;
        if (alarm_hit) alarm_cnt++;
        if (day_wrap)  wrap_cnt++;
        if (load_ok || load_err) ldp_cnt++;
    endtask

    task automatic wait_tick(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < budget && !seen) begin
            step();
            cycles++;
            if (sec_tick) seen = 1'b1;
        end
    endtask

    task automatic do_reset(input logic run);
        rst_n = 1'b0; run_en = 1'b0; load_valid = 1'b0; load_time = '0;
        step();
        step();
        rst_n  = 1'b1;
        run_en = run;
        sbq.delete();
        now_s = 0;
    endtask

    task automatic test_reset();
        int t0;
        rst_n = 1'b0; run_en = 1'b0; load_valid = 1'b0; load_time = '0;
        alarm_en = 1'b0; alarm_time = '0;
        #1;
        vec_cnt++;
        if (digits !== 24'h000000) begin
            miscmp++; $display("FAIL reset_digits got %h want 000000", digits);
        end
        vec_cnt++;
        if (load_ready !== 1'b1) begin
            miscmp++; $display("FAIL reset_ready got %b want 1", load_ready);
        end
        vec_cnt++;
        if ({load_ok, load_err, alarm_hit, sec_tick, day_wrap} !== 5'b0) begin
            miscmp++;
            $display("FAIL reset_pulses got %b want 00000",
                     {load_ok, load_err, alarm_hit, sec_tick, day_wrap});
        end
        step();
        step();
        rst_n = 1'b1;
        t0 = tick_cnt;
        repeat (3 * TD) step();
        vec_cnt++;
        if (tick_cnt != t0 || digits !== 24'h000000) begin
            miscmp++;
            $display("FAIL stop_holds got ticks=%0d digits=%h want 0/000000", tick_cnt - t0, digits);
        end
    endtask

    task automatic test_count();
        int cyc; bit seen; exp_t e; bit have; int want;
        do_reset(1'b1);
        for (int i = 1; i <= 10; i++) push_sec(i, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            wait_tick(3 * TD, cyc, seen);
            pop_exp(e, have);
            want = (i == 1) ? TD + 1 : TD;
            vec_cnt++;
            if (!seen || cyc != want) begin
                miscmp++;
                $display("FAIL count_interval[%0d] got %0d cycles seen=%0b want %0d", i, cyc, seen, want);
            end
            vec_cnt++;
            if (!have || digits !== e.d || day_wrap !== e.wrap || alarm_hit !== e.alarm) begin
                miscmp++;
                $display("FAIL count_value[%0d] got %h/%b/%b want %h/%b/%b",
                         i, digits, day_wrap, alarm_hit, e.d, e.wrap, e.alarm);
            end
        end
        now_s = 10;
    endtask

    task automatic test_load_wrap();
        int cyc; bit seen; exp_t e; bit have; int w0;
        wait_tick(3 * TD, cyc, seen);
        now_s++;
        load_valid = 1'b1; load_time = 24'h235958;
        step();
        load_valid = 1'b0;
        vec_cnt++;
        if (load_ready !== 1'b0 || load_ok !== 1'b0) begin
            miscmp++; $display("FAIL wrap_chk_cycle got ready=%b ok=%b want 0/0", load_ready, load_ok);
        end
        step();
        vec_cnt++;
        if (load_ok !== 1'b1 || load_err !== 1'b0 || digits !== 24'h235958 || load_ready !== 1'b1) begin
            miscmp++;
            $display("FAIL wrap_load got ok=%b err=%b digits=%h ready=%b want 1/0/235958/1",
                     load_ok, load_err, digits, load_ready);
        end
        w0 = wrap_cnt;
        push_sec(86399, 1'b0);
        push_sec(86400, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_tick(3 * TD, cyc, seen);
            pop_exp(e, have);
            vec_cnt++;
            if (!seen || cyc != TD || !have || digits !== e.d || day_wrap !== e.wrap) begin
                miscmp++;
                $display("FAIL wrap_tick[%0d] got cyc=%0d %h/%b want cyc=%0d %h/%b",
                         i, cyc, digits, day_wrap, TD, e.d, e.wrap);
            end
        end
        vec_cnt++;
        if (wrap_cnt - w0 != 1) begin
            miscmp++; $display("FAIL wrap_count got %0d want 1", wrap_cnt - w0);
        end
        now_s = 0;
    endtask

    task automatic test_load_err();
        int cyc; bit seen; exp_t e; bit have;
        wait_tick(3 * TD, cyc, seen);
        now_s++;
        vec_cnt++;
        if (load_ready !== 1'b1) begin
            miscmp++; $display("FAIL err_ready_n got %b want 1", load_ready);
        end
        load_valid = 1'b1; load_time = 24'h126000;
        step();
        load_valid = 1'b0;
        vec_cnt++;
        if (load_ready !== 1'b0) begin
            miscmp++; $display("FAIL err_ready_n1 got %b want 0", load_ready);
        end
        step();
        vec_cnt++;
        if (load_err !== 1'b1 || load_ok !== 1'b0 || digits !== to_bcd(now_s) || load_ready !== 1'b1) begin
            miscmp++;
            $display("FAIL err_result got err=%b ok=%b digits=%h ready=%b want 1/0/%h/1",
                     load_err, load_ok, digits, load_ready, to_bcd(now_s));
        end
        // Prescaler advanced once before CHK froze it, so 3 cycles remain
        now_s++;
        push_sec(now_s, 1'b0);
        wait_tick(3 * TD, cyc, seen);
        pop_exp(e, have);
        vec_cnt++;
        if (!seen || cyc != TD - 1 || !have || digits !== e.d) begin
            miscmp++;
            $display("FAIL err_presc_kept got cyc=%0d digits=%h want cyc=%0d %h", cyc, digits, TD - 1, e.d);
        end
    endtask

    task automatic test_hour_carry();
        int cyc; bit seen; exp_t e; bit have;
        logic [23:0] bad [4];
        bad[0] = 24'h240000; bad[1] = 24'h000060; bad[2] = 24'h1A0000; bad[3] = 24'h095A00;
        wait_tick(3 * TD, cyc, seen);
        load_valid = 1'b1; load_time = 24'h195959;
        step();
        load_valid = 1'b0;
        step();
        now_s = 19 * 3600 + 59 * 60 + 59;
        vec_cnt++;
        if (load_ok !== 1'b1 || digits !== 24'h195959) begin
            miscmp++; $display("FAIL hour_load got ok=%b digits=%h want 1/195959", load_ok, digits);
        end
        now_s++;
        push_sec(now_s, 1'b0);
        wait_tick(3 * TD, cyc, seen);
        pop_exp(e, have);
        vec_cnt++;
        if (!seen || !have || digits !== e.d || digits !== 24'h200000) begin
            miscmp++; $display("FAIL hour_carry got %h want 200000", digits);
        end
        for (int i = 0; i < 4; i++) begin
            wait_tick(3 * TD, cyc, seen);
            now_s++;
            load_valid = 1'b1; load_time = bad[i];
            step();
            load_valid = 1'b0;
            step();
            vec_cnt++;
            if (load_err !== 1'b1 || load_ok !== 1'b0 || digits !== to_bcd(now_s)) begin
                miscmp++;
                $display("FAIL bad_load[%h] got err=%b ok=%b digits=%h want 1/0/%h",
                         bad[i], load_err, load_ok, digits, to_bcd(now_s));
            end
        end
    endtask

    task automatic test_alarm();
        int cyc; bit seen; exp_t e; bit have; int a0;
        alarm_time = 24'h000003;
        alarm_en   = 1'b1;
        do_reset(1'b1);
        a0 = alarm_cnt;
        for (int i = 1; i <= 5; i++) push_sec(i, i == 3);
        for (int i = 1; i <= 5; i++) begin
            wait_tick(3 * TD, cyc, seen);
            pop_exp(e, have);
            vec_cnt++;
            if (!seen || !have || digits !== e.d || alarm_hit !== e.alarm) begin
                miscmp++;
                $display("FAIL alarm_on[%0d] got %h/%b want %h/%b", i, digits, alarm_hit, e.d, e.alarm);
            end
        end
        // Loading the alarm time itself must not fire the alarm
        load_valid = 1'b1; load_time = 24'h000003;
        step();
        load_valid = 1'b0;
        step();
        vec_cnt++;
        if (load_ok !== 1'b1 || alarm_cnt - a0 != 1) begin
            miscmp++;
            $display("FAIL alarm_on_load got ok=%b hits=%0d want 1/1", load_ok, alarm_cnt - a0);
        end
        alarm_en = 1'b0;
        do_reset(1'b1);
        a0 = alarm_cnt;
        for (int i = 1; i <= 5; i++) push_sec(i, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            wait_tick(3 * TD, cyc, seen);
            pop_exp(e, have);
            vec_cnt++;
            if (!seen || !have || digits !== e.d || alarm_hit !== e.alarm) begin
                miscmp++;
                $display("FAIL alarm_off[%0d] got %h/%b want %h/%b", i, digits, alarm_hit, e.d, e.alarm);
            end
        end
        vec_cnt++;
        if (alarm_cnt != a0) begin
            miscmp++; $display("FAIL alarm_off_count got %0d want 0", alarm_cnt - a0);
        end
        now_s = 5;
    endtask

    task automatic test_hold_and_reset();
        int cyc; bit seen; exp_t e; bit have; int t0, l0;
        wait_tick(3 * TD, cyc, seen);
        now_s++;
        step();
        run_en = 1'b0;
        step();
        step();
        step();
        run_en = 1'b1;
        now_s++;
        push_sec(now_s, 1'b0);
        wait_tick(3 * TD, cyc, seen);
        pop_exp(e, have);
        vec_cnt++;
        if (!seen || cyc + 4 != TD + 3 || !have || digits !== e.d) begin
            miscmp++;
            $display("FAIL hold_delay got interval=%0d digits=%h want %0d %h", cyc + 4, digits, TD + 3, e.d);
        end
        wait_tick(3 * TD, cyc, seen);
        load_valid = 1'b1; load_time = 24'h123456;
        step();
        load_valid = 1'b0;
        rst_n = 1'b0;
        run_en = 1'b0;
        #1;
        vec_cnt++;
        if (digits !== 24'h000000 || load_ready !== 1'b1 ||
            {load_ok, load_err, alarm_hit, sec_tick, day_wrap} !== 5'b0) begin
            miscmp++;
            $display("FAIL chk_reset got digits=%h ready=%b pulses=%b want 000000/1/00000",
                     digits, load_ready, {load_ok, load_err, alarm_hit, sec_tick, day_wrap});
        end
        step();
        step();
        rst_n = 1'b1;
        t0 = tick_cnt;
        l0 = ldp_cnt;
        repeat (3 * TD) step();
        vec_cnt++;
        if (tick_cnt != t0 || ldp_cnt != l0 || digits !== 24'h000000) begin
            miscmp++;
            $display("FAIL post_reset_quiet got ticks=%0d loads=%0d digits=%h want 0/0/000000",
                     tick_cnt - t0, ldp_cnt - l0, digits);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_load_wrap();
        test_load_err();
        test_hour_carry();
        test_alarm();
        test_hold_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter that produces the six BCD digits (HH:MM:SS) driven into the seven-segment decoder stage. It divides the system clock down to a one-second tick, counts seconds/minutes/hours in BCD with 24-hour wrap, accepts a validated time load over a valid/ready handshake, and flags an alarm match. Every digit output is a registered 4-bit BCD value in 0..9, directly consumable as a decoder nibble.

## Interface
- TICK_DIV, 100_000_000: clk cycles per second tick; legal range ≥ 2.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run_en  in  1  level; 1 = count, 0 = hold.
- load_valid  in  1  load request; data held stable while valid and not ready.
- load_time  in  24  {h_t,h_u,m_t,m_u,s_t,s_u}, 4 bits each, MSB first.
- load_ready  out  1  load accepted on cycle with load_valid & load_ready.
- load_ok  out  1  one-cycle pulse: load validated and applied.
- load_err  out  1  one-cycle pulse: load rejected, time unchanged.
- alarm_time  in  24  same packing as load_time; compared on seconds only when alarm_en.
- alarm_en  in  1  alarm compare enable.
- alarm_hit  out  1  one-cycle pulse on match.
- digits  out  24  current time, same packing.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- day_wrap  out  1  one-cycle pulse on 23:59:59 → 00:00:00.

## Operation
- FSM states STOP, RUN, CHK. Reset → STOP.
- STOP → RUN when run_en=1; RUN → STOP when run_en=0; either → CHK on accepted load; CHK → RUN if run_en else STOP, always after exactly one cycle.
- load_ready = 1 in STOP and RUN, 0 in CHK.
- Accepted load_time latched into staging register. In CHK: valid iff every digit ≤ 9, s_t ≤ 5, m_t ≤ 5, h_t ≤ 2, and h_t=2 ⇒ h_u ≤ 3. Valid → digits ← staging, prescaler ← 0, load_ok. Invalid → digits unchanged, prescaler unchanged, load_err.
- Prescaler counts 0..TICK_DIV-1 in RUN only; frozen in STOP and CHK. At TICK_DIV-1 it wraps to 0 and issues the tick.
- Tick increments s_u; carry chain s_u(9)→s_t(5)→m_u(9)→m_t(5)→h_u→h_t; hours wrap after 23. h_u wraps at 9 when h_t<2, else at 3.
- alarm_hit when tick occurs and the post-increment time equals alarm_time and alarm_en=1. A load never raises alarm_hit.
- Tick and accepted load in same cycle: tick applies to the counters that cycle; CHK then overwrites if valid.

## Timing
- Reset values: digits=0 (00:00:00), load_ready=1, load_ok=load_err=alarm_hit=sec_tick=day_wrap=0, prescaler=0, state STOP.
- Reset mid-CHK or mid-load: staging discarded, no pulse emitted.
- From RUN entry (prescaler 0), first sec_tick at TICK_DIV-th RUN cycle; digits show new value the cycle after the tick edge (sec_tick, day_wrap, alarm_hit registered, asserted same cycle as new digits).
- Load: accepted cycle N; CHK cycle N+1; digits/load_ok/load_err visible at N+2; load_ready high again at N+2.
- run_en low for one cycle: prescaler holds value, resumes without loss.

## Structure
- Package clock_pkg: state enum (STOP, RUN, CHK), digit field offsets for the 24-bit packing, limits (SEC_T_MAX=5, MIN_T_MAX=5, HR_T_MAX=2, HR_U_MAX_AT_2=3).
- Sub-module bcd_digit_counter: 4-bit register, inc, variable wrap limit input, load/load_val, carry-out; instantiated six times.
- Top holds FSM, prescaler, staging register, range checker, alarm compare.

## Test plan
- TICK_DIV=4, reset, run_en=1 → sec_tick every 4 cycles; digits 000001 after 4 cycles, 000010 after 40.
- Load 23:59:58 while running → load_ok at N+2, two ticks later digits 000000 with day_wrap pulse coincident.
- Load 12:60:00 → load_err at N+2, digits and prescaler unchanged, load_ready low only at N+1.
- Load 19:59:59 then tick → 20:00:00; load 24:00:00 → load_err.
- alarm_time 00:00:03, alarm_en=1 from reset run → single alarm_hit when digits become 000003; alarm_en=0 → none.
- run_en toggled low for 3 cycles mid-second and assert rst_n low during CHK → tick delayed exactly 3 cycles; reset gives 00:00:00, STOP, no pulses.
